mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter DATA_SIZE, default 32: data word width in bits.
REQ-002 Parameter ADDRESS_SIZE, default 16: word address width in bits.
REQ-003 Parameter WAIT_CYCLES, default 1, legal range 0..15: extra Ram access cycles before the data read is sampled.
REQ-004 Port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port req_valid, input, 1: requester presents a request.
REQ-007 Port req_ready, output, 1: controller can accept a request.
REQ-008 Port req_write, input, 1: 1 = write request, 0 = read request.
REQ-009 Port req_address, input, ADDRESS_SIZE: word address of the request.
REQ-010 Port req_data, input, DATA_SIZE: write data.
REQ-011 Port req_burst, input, 1: 4-beat read burst request; present only with MEM_ACCESS_BURST_EN.
REQ-012 Port resp_valid, output, 1: one-cycle response strobe.
REQ-013 Port resp_data, output, DATA_SIZE: read data, all-zero for write acknowledgements.
REQ-014 Port resp_last, output, 1: final beat of a response.
REQ-015 Ports ram_enable (out, 1), ram_read_write (out, 1, 1 = read, 0 = write), ram_address (out, ADDRESS_SIZE) and ram_data_in (out, DATA_SIZE) drive the Ram data port.
REQ-016 Port ram_data_out, input, DATA_SIZE: read data returned from the Ram data port.

Function
REQ-017 The FSM SHALL have three states, IDLE, ACCESS and RESPOND; req_ready SHALL be 1 only in IDLE.
REQ-018 A request SHALL be accepted on the rising edge where req_valid = 1 and the FSM is in IDLE; the address, data, write and burst fields SHALL be registered at that edge, and the FSM SHALL enter ACCESS.
REQ-019 In ACCESS the controller SHALL hold ram_enable = 1 and ram_read_write = ~write, and SHALL drive ram_address from the register; ram_data_in SHALL carry the registered data on writes and zero on reads.
REQ-020 ACCESS SHALL last WAIT_CYCLES+1 cycles, counted by a 4-bit wait counter; on the final ACCESS edge ram_data_out SHALL be captured into resp_data on reads, and the FSM SHALL enter RESPOND.
REQ-021 In RESPOND, resp_valid SHALL be 1 for exactly one cycle, with no backpressure; the FSM SHALL then return to IDLE (single access) or re-enter ACCESS (remaining burst beats).
REQ-022 Single-access latency: resp_valid SHALL be high in the cycle beginning WAIT_CYCLES+2 rising edges after the accepting edge.
REQ-023 A write SHALL produce one response with resp_data = 0 and resp_last = 1.
REQ-024 Outside ACCESS, ram_enable SHALL be 0, ram_read_write SHALL be 1, and ram_address and ram_data_in SHALL hold their last values.
REQ-025 req_valid asserted while the FSM is not in IDLE SHALL be ignored; no queueing.
REQ-026 With WAIT_CYCLES = 0, ACCESS SHALL last exactly 1 cycle.

Reset
REQ-027 Asserting reset SHALL immediately force: state to IDLE, req_ready = 1, resp_valid = 0, resp_last = 0, resp_data = 0, ram_enable = 0, ram_read_write = 1, ram_address = 0, ram_data_in = 0, and the wait and beat counters to 0.
REQ-028 Reset asserted mid-access SHALL abort the operation without any response; the first request after reset deassertion SHALL be served normally.

Configuration
REQ-029 With macro MEM_ACCESS_BURST_EN defined, a read accepted with req_burst = 1 SHALL perform 4 beats at addresses A, A+1, A+2, A+3, wrapping modulo 2^ADDRESS_SIZE; each beat SHALL be a full ACCESS plus RESPOND, and resp_last SHALL be 1 only on beat 4.
REQ-030 With MEM_ACCESS_BURST_EN defined, req_burst SHALL be ignored on writes.
REQ-031 Without MEM_ACCESS_BURST_EN, the req_burst port and the beat counter SHALL be absent and every response SHALL have resp_last = 1.

Structure
REQ-032 Package mem_access_pkg SHALL hold the state enum, BURST_LEN = 4, RW_READ = 1 and RW_WRITE = 0.
REQ-033 The block SHALL be a single module with no sub-module; the counters stay inline.

Verification
REQ-034 Single read: preload Ram word 3 = 0xDEADBEEF, WAIT_CYCLES = 1, read addr 3 -> one resp_valid pulse 3 edges after acceptance, resp_data = 0xDEADBEEF, resp_last = 1.
REQ-035 Write then read: write 0x12345678 to addr 5, then read addr 5 -> write ack with resp_data = 0; read returns 0x12345678; ram_read_write = 0 only during the write ACCESS.
REQ-036 Busy ignore: second req_valid presented during ACCESS -> req_ready = 0; exactly one response; the Ram sees only the first address.
REQ-037 Reset mid-access: assert reset during ACCESS -> ram_enable = 0 immediately; no resp_valid; the next read completes correctly.
REQ-038 Burst wrap (MEM_ACCESS_BURST_EN): burst read at addr 0xFFFE -> 4 responses from addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; resp_last = 1 only on the 4th.
REQ-039 WAIT_CYCLES = 0: read addr 0 -> resp_valid high 2 edges after acceptance.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the single-port Ram access controller.
// Holds the controller FSM encoding, burst length and Ram read/write polarity.
// Pure declarations; no logic, no latency, no flow control.
package mem_access_pkg;

    // Controller FSM states: wait for a request, drive the Ram, strobe a response.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    // Number of beats in a read burst.
    localparam int BURST_LEN = 4;

    // Width of the beat counter used for bursts.
    localparam int BEAT_W = $clog2(BURST_LEN);

    // Polarity of ram_read_write.
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Translate a request's write flag into the Ram port direction.
    function automatic logic ram_dir(input logic write);
        return write ? RW_WRITE : RW_READ;
    endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Single-port Ram access controller: one request at a time, optional 4-beat read bursts (MEM_ACCESS_BURST_EN).
// Latency: response strobe in the cycle starting WAIT_CYCLES+2 edges after acceptance; bursts repeat every WAIT_CYCLES+2.
// Backpressure: req_ready only in IDLE, requests seen while busy are dropped; responses cannot be stalled.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int DATA_SIZE    = 32,
    parameter int ADDRESS_SIZE = 16,
    parameter int WAIT_CYCLES  = 1
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDRESS_SIZE-1:0] req_address,
    input  logic [DATA_SIZE-1:0]    req_data,
`ifdef MEM_ACCESS_BURST_EN
    input  logic                    req_burst,
`endif

    output logic                    resp_valid,
    output logic [DATA_SIZE-1:0]    resp_data,
    output logic                    resp_last,

    output logic                    ram_enable,
    output logic                    ram_read_write,
    output logic [ADDRESS_SIZE-1:0] ram_address,
    output logic [DATA_SIZE-1:0]    ram_data_in,
    input  logic [DATA_SIZE-1:0]    ram_data_out
);

    // Index of the final ACCESS cycle as seen by the 4-bit wait counter.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    state_t                  state_q, state_d;
    logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
    logic [DATA_SIZE-1:0]    wdata_q, wdata_d;
    logic                    write_q, write_d;
    logic [3:0]              wait_q, wait_d;
    logic [DATA_SIZE-1:0]    resp_data_q, resp_data_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    resp_last_q, resp_last_d;
    logic                    last_beat;

`ifdef MEM_ACCESS_BURST_EN
    logic                    burst_q, burst_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;

    // A burst ends on its fourth beat; non-burst operations are always their own last beat.
    assign last_beat = ~burst_q | (beat_q == BEAT_W'(BURST_LEN - 1));
`else
    assign last_beat = 1'b1;
`endif

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath next values; every field defaults to holding.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        wait_d       = wait_q;
        resp_data_d  = resp_data_q;
        resp_valid_d = 1'b0;
        resp_last_d  = 1'b0;
`ifdef MEM_ACCESS_BURST_EN
        burst_d      = burst_q;
        beat_d       = beat_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = ACCESS;
                    addr_d  = req_address;
                    write_d = req_write;
                    // Reads present zero on the Ram write-data lines.
                    wdata_d = req_write ? req_data : '0;
                    wait_d  = '0;
`ifdef MEM_ACCESS_BURST_EN
                    // Bursts are read-only; a burst flag on a write is dropped here.
                    burst_d = req_burst & ~req_write;
                    beat_d  = '0;
`endif
                end
            end
            ACCESS: begin
                if (wait_q == WAIT_LAST) begin
                    state_d     = RESPOND;
                    wait_d      = '0;
                    resp_data_d = write_q ? '0 : ram_data_out;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            RESPOND: begin
                // The strobe is registered, so it shows in the cycle after RESPOND.
                resp_valid_d = 1'b1;
                resp_last_d  = last_beat;
                if (last_beat) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACCESS;
                    addr_d  = addr_q + 1'b1;
`ifdef MEM_ACCESS_BURST_EN
                    beat_d  = beat_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request registers, wait counter and response registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            wait_q       <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            wait_q       <= wait_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
            resp_last_q  <= resp_last_d;
        end
    end

`ifdef MEM_ACCESS_BURST_EN
    // Burst flag and beat counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            burst_q <= 1'b0;
            beat_q  <= '0;
        end else begin
            burst_q <= burst_d;
            beat_q  <= beat_d;
        end
    end
`endif

    // Ram address and write data come straight from registers, so they hold
    // their last values outside ACCESS; strobe and direction are gated by state.
    assign req_ready      = (state_q == IDLE);
    assign ram_enable     = (state_q == ACCESS);
    assign ram_read_write = (state_q == ACCESS) ? ram_dir(write_q) : RW_READ;
    assign ram_address    = addr_q;
    assign ram_data_in    = wdata_q;

    assign resp_valid     = resp_valid_q;
    assign resp_data      = resp_data_q;
    assign resp_last      = resp_last_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (WAIT_CYCLES=1 and 0) sharing one Ram array.
// A timeline model predicts every cycle of each transaction; expected data comes from a shadow memory.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_mem_access_ctrl;

`ifdef MEM_ACCESS_BURST_EN
    localparam bit BURST_ON = 1'b1;
`else
    localparam bit BURST_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sel   = 1'b1;   // 1: WAIT_CYCLES=1 instance, 0: WAIT_CYCLES=0 instance
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_address = '0;
    logic [31:0] req_data = '0;
    logic        req_burst = 1'b0;

    logic        rdy1, rv1, rl1, en1, rw1, rdy0, rv0, rl0, en0, rw0;
    logic [31:0] rd1, din1, dout1, rd0, din0, dout0;
    logic [15:0] ad1, ad0;

    logic        o_ready, o_valid, o_last, o_en, o_rw;
    logic [31:0] o_data, o_din;
    logic [15:0] o_addr;

    logic [31:0] ram_mem [0:65535];
    logic [31:0] ref_mem [0:65535];
    logic        pre_we = 1'b0;
    logic [15:0] pre_a = '0;
    logic [31:0] pre_d = '0;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clock = ~clock;

    mem_access_ctrl #(.DATA_SIZE(32), .ADDRESS_SIZE(16), .WAIT_CYCLES(1)) u_dut_w1 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid & sel), .req_ready(rdy1), .req_write(req_write),
        .req_address(req_address), .req_data(req_data),
`ifdef MEM_ACCESS_BURST_EN
        .req_burst(req_burst),
`endif
        .resp_valid(rv1), .resp_data(rd1), .resp_last(rl1),
        .ram_enable(en1), .ram_read_write(rw1), .ram_address(ad1),
        .ram_data_in(din1), .ram_data_out(dout1)
    );

    mem_access_ctrl #(.DATA_SIZE(32), .ADDRESS_SIZE(16), .WAIT_CYCLES(0)) u_dut_w0 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid & ~sel), .req_ready(rdy0), .req_write(req_write),
        .req_address(req_address), .req_data(req_data),
`ifdef MEM_ACCESS_BURST_EN
        .req_burst(req_burst),
`endif
        .resp_valid(rv0), .resp_data(rd0), .resp_last(rl0),
        .ram_enable(en0), .ram_read_write(rw0), .ram_address(ad0),
        .ram_data_in(din0), .ram_data_out(dout0)
    );

    // Shared Ram: asynchronous read, synchronous write from either instance or the preload port.
    assign dout1 = ram_mem[ad1];
    assign dout0 = ram_mem[ad0];
    always @(posedge clock) begin
        if (pre_we) ram_mem[pre_a] <= pre_d;
        if (en1 && !rw1) ram_mem[ad1] <= din1;
        if (en0 && !rw0) ram_mem[ad0] <= din0;
    end

    // Observe whichever instance is under test.
    always_comb begin
        o_ready = sel ? rdy1 : rdy0;
        o_valid = sel ? rv1  : rv0;
        o_last  = sel ? rl1  : rl0;
        o_en    = sel ? en1  : en0;
        o_rw    = sel ? rw1  : rw0;
        o_data  = sel ? rd1  : rd0;
        o_din   = sel ? din1 : din0;
        o_addr  = sel ? ad1  : ad0;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [15:0] addr_of(input int k);
        return (k < 32) ? 16'(k) : 16'(16'hFFF0 + (k - 32));
    endfunction

    // One transaction, called at a falling edge with the selected instance idle.
    // Cycle j counts cycles from the accepting edge; each beat spans W+2 cycles
    // (W+1 of Ram access, one of response), and beat b's strobe appears at j=(b+1)(W+2).
    task automatic run_txn(input bit wr, input logic [15:0] a, input logic [31:0] d,
                           input bit bu, input bit poke);
        int          w, p, beats, n, b, ph, vb;
        logic [15:0] ea;
        logic [31:0] ed;
        w     = sel ? 1 : 0;
        p     = w + 2;
        beats = (BURST_ON && bu && !wr) ? 4 : 1;
        n     = beats * p;
        req_write = wr; req_address = a; req_data = d; req_burst = bu; req_valid = 1'b1;
        @(posedge clock);
        for (int j = 0; j <= n; j++) begin
            @(negedge clock);
            b  = j / p;
            ph = j % p;
            ea = a + 16'((b < beats) ? b : beats - 1);
            check_val("req_ready", o_ready, j == n);
            check_val("ram_enable", o_en, (j < n) && (ph <= w));
            check_val("ram_read_write", o_rw, !((j < n) && (ph <= w) && wr));
            check_val("ram_address", o_addr, ea);
            check_val("ram_data_in", o_din, wr ? d : 32'h0);
            check_val("resp_valid", o_valid, (j > 0) && (ph == 0));
            if ((j > 0) && (ph == 0)) begin
                vb = b - 1;
                ed = wr ? 32'h0 : ref_mem[16'(a + 16'(vb))];
                check_val("resp_data", o_data, ed);
                check_val("resp_last", o_last, vb == beats - 1);
            end
            if (j == 0 && poke) begin
                req_valid = 1'b1; req_address = a ^ 16'h0040; req_write = ~wr; req_data = ~d;
            end else if (j == 0 || j == n - 1) begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        if (wr) ref_mem[a] = d;
    endtask

    task automatic check_reset_state();
        check_val("rst req_ready", rdy1, 1'b1);
        check_val("rst resp_valid", rv1, 1'b0);
        check_val("rst resp_last", rl1, 1'b0);
        check_val("rst resp_data", rd1, 32'h0);
        check_val("rst ram_enable", en1, 1'b0);
        check_val("rst ram_read_write", rw1, 1'b1);
        check_val("rst ram_address", ad1, 16'h0);
        check_val("rst ram_data_in", din1, 32'h0);
        check_val("rst w0 ram_enable", en0, 1'b0);
        check_val("rst w0 req_ready", rdy0, 1'b1);
    endtask

    initial begin
        logic [31:0] v;
        reset = 1'b1;
        #1;
        check_reset_state();
        // Preload the words the stimulus can touch, mirrored in the shadow memory.
        for (int k = 0; k < 52; k++) begin
            @(negedge clock);
            pre_a  = (k < 36) ? 16'(k) : 16'(16'hFFF0 + (k - 36));
            v      = (pre_a == 16'd3) ? 32'hDEADBEEF : $urandom;
            pre_d  = v;
            pre_we = 1'b1;
            ref_mem[pre_a] = v;
        end
        @(negedge clock);
        pre_we = 1'b0;
        check_reset_state();
        reset = 1'b0;
        @(negedge clock);

        // Single read with one wait cycle.
        sel = 1'b1;
        run_txn(1'b0, 16'd3, 32'h0, 1'b0, 1'b0);
        // Write then read back.
        run_txn(1'b1, 16'd5, 32'h12345678, 1'b0, 1'b0);
        run_txn(1'b0, 16'd5, 32'h0, 1'b0, 1'b0);
        // Second request presented while busy must be dropped.
        run_txn(1'b0, 16'd9, 32'h0, 1'b0, 1'b1);
        // Burst wrapping past the top of the address space.
        run_txn(1'b0, 16'hFFFE, 32'h0, 1'b1, 1'b0);
        // Burst flag on a write is ignored.
        run_txn(1'b1, 16'd12, 32'hA5A5_0F0F, 1'b1, 1'b0);
        // Zero wait cycles.
        sel = 1'b0;
        run_txn(1'b0, 16'd0, 32'h0, 1'b0, 1'b0);
        run_txn(1'b1, 16'd2, 32'h0BAD_F00D, 1'b0, 1'b1);
        run_txn(1'b0, 16'd2, 32'h0, 1'b0, 1'b0);

        // Reset in the middle of an access aborts it without a response.
        sel = 1'b1;
        req_write = 1'b0; req_address = 16'd7; req_burst = 1'b0; req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        check_val("pre-abort ram_enable", en1, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_reset_state();
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_val("abort resp_valid", rv1, 1'b0);
        end
        reset = 1'b0;
        @(negedge clock);
        check_val("post-abort resp_valid", rv1, 1'b0);
        run_txn(1'b0, 16'd7, 32'h0, 1'b0, 1'b0);

        // Randomized mix over both instances.
        for (int t = 0; t < 60; t++) begin
            sel = 1'($urandom_range(0, 1));
            run_txn(1'($urandom_range(0, 1)), addr_of($urandom_range(0, 47)), $urandom,
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
